dcache_line_ram: RTL and testbench

DCACHE_LINE_RAM -- requirements
Module: dcache_line_ram

---
 rtl/dcache_line_ram.sv | 166 ++++++++++++++++
 tb/tb_dcache_line_ram.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_line_ram
//  Description : Responder end of the dcache-to-RAM line protocol. Holds
//                LINES x 128-bit lines, serves one read or write at a time
//                and answers each request with a one-cycle ready pulse
//                LATENCY cycles after acceptance. Writes win over reads
//                when both are requested in the same idle cycle.
//                Optional macro DCACHE_LINE_RAM_STATS_EN enables the
//                completed-read/write counters (tied to 0 otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_line_ram #(
    parameter int LINES   = 1024,
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         RESET,
    input  logic [31:0]  read_addr,
    input  logic         read_addr_valid,
    output logic         read_addr_ready,
    output logic [127:0] read_data,
    input  logic [31:0]  write_addr,
    input  logic         write_addr_valid,
    input  logic [127:0] write_data,
    output logic         write_addr_ready,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count
);

    localparam int c_IDX_W = $clog2(LINES);
    // Counter holds LATENCY-1 at most; keep at least one bit for LATENCY=1.
    localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic                 r_is_write;
    logic [c_IDX_W-1:0]   r_idx;
    logic [127:0]         r_wdata;

    // Backing store starts at zero and is never touched by reset.
    logic [127:0]         r_mem [LINES] = '{default: '0};

    logic                 w_accept_wr;
    logic                 w_accept_rd;
    logic                 w_resp_fire;
    logic                 w_unused_addr_bits;

    // Only the line-index field of each address matters; the rest wraps.
    assign w_unused_addr_bits = ^{read_addr[31:4+c_IDX_W], read_addr[3:0],
                                  write_addr[31:4+c_IDX_W], write_addr[3:0]};

    assign w_accept_wr = (r_state == IDLE) && write_addr_valid;
    assign w_accept_rd = (r_state == IDLE) && read_addr_valid && !write_addr_valid;

    // A reset landing on the response cycle cancels the pulse and the commit.
    assign w_resp_fire = (r_state == RESP) && !RESET;

    assign read_addr_ready  = w_resp_fire && !r_is_write;
    assign write_addr_ready = w_resp_fire && r_is_write;
    assign read_data        = read_addr_ready ? r_mem[r_idx] : '0;

    // Next-state and latency-counter logic.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (write_addr_valid) begin
                    w_cnt_next   = c_CNT_LOAD;
                    w_state_next = (LATENCY == 1) ? RESP : WR_WAIT;
                end else if (read_addr_valid) begin
                    w_cnt_next   = c_CNT_LOAD;
                    w_state_next = (LATENCY == 1) ? RESP : RD_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                w_cnt_next = r_cnt - c_CNT_ONE;
                if (r_cnt <= c_CNT_ONE) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Capture address/data at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_is_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
        end else if (w_accept_wr) begin
            r_is_write <= 1'b1;
            r_idx      <= write_addr[4+c_IDX_W-1:4];
            r_wdata    <= write_data;
        end else if (w_accept_rd) begin
            r_is_write <= 1'b0;
            r_idx      <= read_addr[4+c_IDX_W-1:4];
        end
    end

    // Commit a write at the edge closing its ready cycle.
    always_ff @(posedge clk) begin
        if (w_resp_fire && r_is_write) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

`ifdef DCACHE_LINE_RAM_STATS_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    // Count completed transfers; both counters wrap naturally.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (read_addr_ready) begin
                r_rd_count <= r_rd_count + 32'd1;
            end
            if (write_addr_ready) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_line_ram
//  Description : Directed self-checking bench for dcache_line_ram with
//                hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_line_ram;

    localparam int LINES = 1024;
    localparam int LAT   = 4;

    logic         clk;
    logic         RESET;
    logic [31:0]  read_addr;
    logic         read_addr_valid;
    logic         read_addr_ready;
    logic [127:0] read_data;
    logic [31:0]  write_addr;
    logic         write_addr_valid;
    logic [127:0] write_data;
    logic         write_addr_ready;
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;

    int n_checks = 0;
    int n_errors = 0;

    dcache_line_ram #(.LINES(LINES), .LATENCY(LAT)) u_dut (
        .clk              (clk),
        .RESET            (RESET),
        .read_addr        (read_addr),
        .read_addr_valid  (read_addr_valid),
        .read_addr_ready  (read_addr_ready),
        .read_data        (read_data),
        .write_addr       (write_addr),
        .write_addr_valid (write_addr_valid),
        .write_data       (write_data),
        .write_addr_ready (write_addr_ready),
        .rd_count         (rd_count),
        .wr_count         (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a read at cycle 0 and expect the pulse on cycle LAT with data exp.
    task automatic do_read(input logic [31:0] a, input logic [127:0] exp, input string tag);
        int cyc;
        bit seen;
        @(negedge clk);
        read_addr       = a;
        read_addr_valid = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc <= LAT + 4) begin
            if (read_addr_ready) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, "_lat"}, 128'(cyc), 128'(LAT));
        check({tag, "_data"}, read_data, exp);
        read_addr_valid = 1'b0;
        read_addr       = 32'hFFFF_FFF0;
        @(negedge clk);
        check({tag, "_pulse_end"}, {126'd0, read_addr_ready, write_addr_ready}, 128'd0);
    endtask

    // Issue a write; scramble the inputs once accepted to prove they were captured.
    task automatic do_write(input logic [31:0] a, input logic [127:0] d, input string tag);
        int cyc;
        bit seen;
        @(negedge clk);
        write_addr       = a;
        write_data       = d;
        write_addr_valid = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc <= LAT + 4) begin
            if (write_addr_ready) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
                if (cyc == 1) begin
                    write_addr = a ^ 32'h0000_0100;
                    write_data = ~d;
                end
            end
        end
        check({tag, "_lat"}, 128'(cyc), 128'(LAT));
        check({tag, "_no_rd"}, {127'd0, read_addr_ready}, 128'd0);
        write_addr_valid = 1'b0;
        @(negedge clk);
        check({tag, "_pulse_end"}, {126'd0, read_addr_ready, write_addr_ready}, 128'd0);
    endtask

    initial begin
        int  cyc;
        bit  seen;
        logic [127:0] ones;
        ones = '1;

        RESET            = 1'b1;
        read_addr        = '0;
        read_addr_valid  = 1'b0;
        write_addr       = '0;
        write_addr_valid = 1'b0;
        write_data       = '0;
        repeat (3) @(negedge clk);
        RESET = 1'b0;

        check("rst_rd_ready", {127'd0, read_addr_ready}, 128'd0);
        check("rst_wr_ready", {127'd0, write_addr_ready}, 128'd0);
        check("rst_read_data", read_data, 128'd0);
        check("rst_counts", {64'd0, rd_count, wr_count}, 128'd0);

        // Fresh store reads zero.
        do_read(32'h0000_0040, 128'd0, "rd_40");

        // Write then read the same line through a different byte offset.
        do_write(32'h0000_1230, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, "wr_1230");
        do_read(32'h0000_123C, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, "rd_123c");

        // Simultaneous requests: write answered on cycle 4, read on cycle 9.
        @(negedge clk);
        write_addr       = 32'h0000_0020;
        write_data       = ones;
        write_addr_valid = 1'b1;
        read_addr        = 32'h0000_0020;
        read_addr_valid  = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc <= LAT + 4) begin
            if (write_addr_ready) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("both_wr_lat", 128'(cyc), 128'(LAT));
        check("both_rd_not_yet", {127'd0, read_addr_ready}, 128'd0);
        write_addr_valid = 1'b0;
        seen = 1'b0;
        while (!seen && cyc <= 2 * LAT + 6) begin
            if (read_addr_ready) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("both_rd_lat", 128'(cyc), 128'(2 * LAT + 1));
        check("both_rd_data", read_data, ones);
        read_addr_valid = 1'b0;
        @(negedge clk);

        // Address wrap: 0x4010 and 0x0010 share line 1 when LINES=1024.
        do_write(32'h0000_4010, 128'h5, "wr_4010");
        do_read(32'h0000_0010, 128'h5, "rd_wrap");

        // Reset during the wait of a write aborts it.
        @(negedge clk);
        write_addr       = 32'h0000_0080;
        write_data       = 128'h7;
        write_addr_valid = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (write_addr_ready || read_addr_ready) seen = 1'b1;
        end
        RESET            = 1'b1;
        write_addr_valid = 1'b0;
        @(negedge clk);
        RESET = 1'b0;
        repeat (LAT + 3) begin
            if (write_addr_ready || read_addr_ready) seen = 1'b1;
            @(negedge clk);
        end
        check("abort_no_ready", {127'd0, seen}, 128'd0);
        check("abort_counts", {64'd0, rd_count, wr_count}, 128'd0);
        do_read(32'h0000_0080, 128'd0, "rd_abort");

        // Two more writes and two more reads: three reads, two writes since reset.
        do_write(32'h0000_0090, 128'h1111_2222_3333_4444_5555_6666_7777_8888, "wr_90");
        do_write(32'h0000_00A0, 128'hA5A5_0000_0000_0000_0000_0000_0000_5A5A, "wr_a0");
        do_read(32'h0000_0090, 128'h1111_2222_3333_4444_5555_6666_7777_8888, "rd_90");
        do_read(32'h0000_00A0, 128'hA5A5_0000_0000_0000_0000_0000_0000_5A5A, "rd_a0");
`ifdef DCACHE_LINE_RAM_STATS_EN
        check("rd_count", 128'(rd_count), 128'd3);
        check("wr_count", 128'(wr_count), 128'd2);
`else
        check("rd_count", 128'(rd_count), 128'd0);
        check("wr_count", 128'(wr_count), 128'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
